stopwatch_mux_core: RTL and testbench

Parametrised stopwatch/timer core. Successor to the fixed 4-digit stopwatch core, adding configurable digit count, count-down mode, lap freeze and parallel load. It keeps an N-digit BCD count advanced by an internal prescaled tick. It drives a time-multiplexed, active-low seven-segment display directly, and sits under the board-level I/O wrapper.

---
 rtl/stopwatch_mux_core.sv | 181 ++++++++++++++++++
 tb/tb_stopwatch_mux_core.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_mux_core.sv
// Stopwatch/timer core: N-digit cascaded BCD count on a prescaled tick, with count-down,
// lap freeze, parallel load and a registered, time-multiplexed active-low 7-segment drive.
module stopwatch_mux_core #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned TICK_DIV    = 500000,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DP_POS      = 2
) (
  input  logic                    m_clk,
  input  logic                    m_rst,
  input  logic                    run,
  input  logic                    down,
  input  logic                    lap,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [6:0]              cathode,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    rollover,
  output logic                    expired
);
  localparam int unsigned CW = 4 * NUM_DIGITS;
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned RW = $clog2(REFRESH_DIV);
  localparam int unsigned DW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [RW-1:0] REF_MAX   = RW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DIG_MAX   = DW'(NUM_DIGITS - 1);

  logic [CW-1:0]         r_count, r_disp;
  logic [PW-1:0]         r_presc;
  logic                  r_halt, r_frozen, r_lap_d1, r_lap_d2;
  logic                  r_rollover, r_expired;
  logic [RW-1:0]         r_refresh;
  logic [DW-1:0]         r_digit;
  logic [NUM_DIGITS-1:0] r_anode;
  logic [6:0]            r_cathode;
  logic                  r_dp;

  logic                  w_run_en, w_tick, w_lap_rise, w_dp_on;
  logic [CW-1:0]         w_inc, w_dec, w_load_clamped, w_disp_val;
  logic [3:0]            w_digit_val;
  logic [6:0]            w_seg;

  // A reached-zero halt only holds while still counting down.
  assign w_run_en   = run & ~(r_halt & down);
  assign w_tick     = w_run_en & (r_presc == PRESC_MAX);
  assign w_lap_rise = r_lap_d1 & ~r_lap_d2;
  assign w_disp_val = r_frozen ? r_disp : r_count;
  assign w_dp_on    = (DP_POS < NUM_DIGITS) && (r_digit == DW'(DP_POS));

  always_comb begin
    logic carry, borrow;
    carry  = 1'b1;
    borrow = 1'b1;
    w_inc  = r_count;
    w_dec  = r_count;
    w_load_clamped = load_val;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (r_count[4*i +: 4] == 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (r_count[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
      if (load_val[4*i +: 4] > 4'd9) w_load_clamped[4*i +: 4] = 4'd9;
    end
  end

  always_ff @(posedge m_clk or posedge m_rst) begin
    if (m_rst) begin
      r_count    <= '0;
      r_presc    <= '0;
      r_halt     <= 1'b0;
      r_rollover <= 1'b0;
      r_expired  <= 1'b0;
    end else if (load) begin
      r_count    <= w_load_clamped;
      r_presc    <= '0;
      r_halt     <= 1'b0;
      r_rollover <= 1'b0;
      r_expired  <= 1'b0;
    end else begin
      r_rollover <= 1'b0;
      r_expired  <= 1'b0;
      if (!down) r_halt <= 1'b0;
      if (w_run_en) r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        if (!down) begin
          r_count    <= w_inc;
          r_rollover <= (w_inc == '0);
        end else if (r_count != '0) begin
          r_count <= w_dec;
          if (w_dec == '0) begin
            r_expired <= 1'b1;
            r_halt    <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge m_clk or posedge m_rst) begin
    if (m_rst) begin
      r_lap_d1 <= 1'b0;
      r_lap_d2 <= 1'b0;
      r_frozen <= 1'b0;
      r_disp   <= '0;
    end else begin
      r_lap_d1 <= lap;
      r_lap_d2 <= r_lap_d1;
      if (w_lap_rise) begin
        r_frozen <= ~r_frozen;
        if (!r_frozen) r_disp <= r_count;
      end
    end
  end

  always_comb begin
    w_digit_val = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_digit == DW'(i)) w_digit_val = w_disp_val[4*i +: 4];
    end
  end

  always_comb begin
    case (w_digit_val)
      4'd0:    w_seg = 7'h40;
      4'd1:    w_seg = 7'h79;
      4'd2:    w_seg = 7'h24;
      4'd3:    w_seg = 7'h30;
      4'd4:    w_seg = 7'h19;
      4'd5:    w_seg = 7'h12;
      4'd6:    w_seg = 7'h02;
      4'd7:    w_seg = 7'h78;
      4'd8:    w_seg = 7'h00;
      4'd9:    w_seg = 7'h10;
      default: w_seg = 7'h7F;
    endcase
  end

  // Anode, cathode and dp are registered from the same index so they never disagree.
  always_ff @(posedge m_clk or posedge m_rst) begin
    if (m_rst) begin
      r_refresh <= '0;
      r_digit   <= '0;
      r_anode   <= '1;
      r_cathode <= 7'h7F;
      r_dp      <= 1'b1;
    end else begin
      if (r_refresh == REF_MAX) begin
        r_refresh <= '0;
        r_digit   <= (r_digit == DIG_MAX) ? '0 : r_digit + 1'b1;
      end else begin
        r_refresh <= r_refresh + 1'b1;
      end
      r_anode   <= ~(NUM_DIGITS'(1) << r_digit);
      r_cathode <= w_seg;
      r_dp      <= ~w_dp_on;
    end
  end

  assign cathode   = r_cathode;
  assign dp        = r_dp;
  assign anode     = r_anode;
  assign count_bcd = r_count;
  assign rollover  = r_rollover;
  assign expired   = r_expired;

endmodule

// File: tb/tb_stopwatch_mux_core.sv
// Directed bench for stopwatch_mux_core: count expectations go through a scoreboard queue,
// display/pulse outputs are compared directly at each step.
module tb_stopwatch_mux_core;
  logic        m_clk = 1'b0;
  logic        m_rst, run, down, lap, load;
  logic [15:0] load_val;
  logic [6:0]  cathode;
  logic        dp, rollover, expired;
  logic [3:0]  anode;
  logic [15:0] count_bcd;

  int checks   = 0;
  int failures = 0;
  string       sb_tag[$];
  logic [15:0] sb_exp[$];

  stopwatch_mux_core #(
    .NUM_DIGITS (4),
    .TICK_DIV   (4),
    .REFRESH_DIV(2),
    .DP_POS     (2)
  ) dut (
    .m_clk    (m_clk),
    .m_rst    (m_rst),
    .run      (run),
    .down     (down),
    .lap      (lap),
    .load     (load),
    .load_val (load_val),
    .cathode  (cathode),
    .dp       (dp),
    .anode    (anode),
    .count_bcd(count_bcd),
    .rollover (rollover),
    .expired  (expired)
  );

  always #5 m_clk = ~m_clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  function automatic logic [3:0] dig_of(input logic [6:0] s);
    for (int d = 0; d < 10; d++) if (seg_of(d) == s) return 4'(d);
    return 4'hF;
  endfunction

  task automatic clk(input int n);
    repeat (n) @(posedge m_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [15:0] exp);
    sb_tag.push_back(tag);
    sb_exp.push_back(exp);
  endtask

  task automatic pop_count();
    string t;
    logic [15:0] e;
    if (sb_exp.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_underflow observed=empty expected=entry");
      return;
    end
    t = sb_tag.pop_front();
    e = sb_exp.pop_front();
    chk(t, {16'h0, count_bcd}, {16'h0, e});
  endtask

  task automatic do_load(input logic [15:0] v);
    load     = 1'b1;
    load_val = v;
    clk(1);
    load     = 1'b0;
  endtask

  // Reassemble the shown value from 8 consecutive anode/cathode samples.
  task automatic read_display(output logic [15:0] val);
    logic [3:0] oh;
    val = 16'hFFFF;
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < 4; i++) begin
        oh = 4'b0001 << i;
        if (anode == ~oh) val[4*i +: 4] = dig_of(cathode);
      end
      clk(1);
    end
  endtask

  initial begin
    logic [15:0] disp;
    logic [3:0]  prev;
    logic [3:0]  exp_an [8];
    int          exp_dg [8];
    logic        exp_dp [8];
    int          ex_cnt, nz_cnt;
    bit          found;

    m_rst = 1'b1; run = 1'b0; down = 1'b0; lap = 1'b0; load = 1'b0; load_val = '0;
    #2;
    chk("rst_cathode", 32'(cathode), 32'h7F);
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_pulses", {30'h0, rollover, expired}, 32'h0);
    push("rst_count", 16'h0000);
    pop_count();
    clk(2);

    // Count up from reset
    m_rst = 1'b0;
    run   = 1'b1;
    clk(1);
    chk("first_slot", {20'h0, anode, cathode, dp}, {20'h0, 4'b1110, seg_of(0), 1'b1});
    push("up_4clk", 16'h0001);
    clk(3);
    pop_count();
    push("up_40clk", 16'h0010);
    clk(36);
    pop_count();

    // Up wrap
    push("load_9999", 16'h9999);
    do_load(16'h9999);
    pop_count();
    clk(3);
    chk("pre_wrap_roll", 32'(rollover), 32'h0);
    push("wrap_count", 16'h0000);
    clk(1);
    pop_count();
    chk("wrap_roll", 32'(rollover), 32'h1);
    clk(1);
    chk("wrap_roll_end", 32'(rollover), 32'h0);

    // Count down to expiry, then hold
    down = 1'b1;
    push("load_0002", 16'h0002);
    do_load(16'h0002);
    pop_count();
    push("down_1", 16'h0001);
    clk(4);
    pop_count();
    chk("down_1_exp", 32'(expired), 32'h0);
    push("down_0", 16'h0000);
    clk(4);
    pop_count();
    chk("expired_pulse", 32'(expired), 32'h1);
    ex_cnt = 0;
    nz_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      clk(1);
      if (expired) ex_cnt++;
      if (count_bcd != 16'h0) nz_cnt++;
    end
    chk("hold_no_expire", 32'(ex_cnt), 32'h0);
    chk("hold_zero", 32'(nz_cnt), 32'h0);
    down = 1'b0;
    push("unhalt_up", 16'h0001);
    clk(4);
    pop_count();

    // Down at zero: no pulse, no change
    down = 1'b1;
    push("load_zero_down", 16'h0000);
    do_load(16'h0000);
    pop_count();
    ex_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      clk(1);
      if (expired || count_bcd != 16'h0) ex_cnt++;
    end
    chk("zero_down_quiet", 32'(ex_cnt), 32'h0);
    down = 1'b0;

    // Clamp and load on a tick cycle
    push("load_clamp", 16'h3979);
    do_load(16'h3A7F);
    pop_count();
    clk(3);
    push("load_on_tick", 16'h0005);
    do_load(16'h0005);
    pop_count();
    push("tick_discarded", 16'h0005);
    clk(3);
    pop_count();
    push("presc_cleared", 16'h0006);
    clk(1);
    pop_count();

    // Pause keeps prescaler phase
    do_load(16'h0000);
    clk(2);
    run = 1'b0;
    push("paused", 16'h0000);
    clk(50);
    pop_count();
    run = 1'b1;
    push("resume_1", 16'h0000);
    clk(1);
    pop_count();
    push("resume_2", 16'h0001);
    clk(1);
    pop_count();

    // Display multiplex
    run = 1'b0;
    push("load_1234", 16'h1234);
    do_load(16'h1234);
    pop_count();
    clk(2);
    prev  = anode;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      clk(1);
      if (anode == 4'b1110 && prev != 4'b1110) found = 1'b1;
      else prev = anode;
    end
    chk("mux_sync", 32'(found), 32'h1);
    exp_an = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111};
    exp_dg = '{4, 4, 3, 3, 2, 2, 1, 1};
    exp_dp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int s = 0; s < 8; s++) begin
      chk($sformatf("mux_slot%0d", s), {20'h0, anode, cathode, dp},
          {20'h0, exp_an[s], seg_of(exp_dg[s]), exp_dp[s]});
      clk(1);
    end

    // Lap freeze
    run = 1'b1;
    do_load(16'h0000);
    push("lap_pre", 16'h0001);
    clk(4);
    pop_count();
    lap = 1'b1;
    clk(2);
    lap = 1'b0;
    push("lap_live", 16'h0003);
    clk(8);
    pop_count();
    read_display(disp);
    chk("lap_frozen", 32'(disp), 32'h0001);
    run = 1'b0;
    push("lap_load", 16'h0077);
    do_load(16'h0077);
    pop_count();
    clk(1);
    read_display(disp);
    chk("lap_still_frozen", 32'(disp), 32'h0001);
    lap = 1'b1;
    clk(2);
    lap = 1'b0;
    clk(2);
    read_display(disp);
    chk("lap_unfrozen", 32'(disp), 32'h0077);

    // Asynchronous reset mid-count
    run = 1'b1;
    do_load(16'h0000);
    clk(6);
    #1;
    m_rst = 1'b1;
    #1;
    chk("arst_cathode", 32'(cathode), 32'h7F);
    chk("arst_anode", 32'(anode), 32'hF);
    chk("arst_dp", 32'(dp), 32'h1);
    chk("arst_pulses", {30'h0, rollover, expired}, 32'h0);
    push("arst_count", 16'h0000);
    pop_count();
    clk(2);
    m_rst = 1'b0;
    clk(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
